instr_cycle_control: RTL

- Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU datapath.
- Drives the program counter strobes (LoadPC, IncPC), the instruction-register load, the accumulator load, memory read/write and the address-mux select.
- Sits between the instruction register/flags and the program_counter, memory and ALU.
- Adds a memory-handshake timeout and a retired-instruction counter for debug.

---
 rtl/instr_cycle_control.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_cycle_control.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: drives PC, IR, ACC and memory strobes,
// with a memory-handshake timeout that halts the core and a debug retired-instruction counter.
module instr_cycle_control #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       LoadPC,
    output logic       IncPC,
    output logic       LoadIR,
    output logic       LoadAcc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       addr_sel,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       timeout_err,
    output logic [7:0] instr_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] LOAD_IR = 3'd2;
    localparam logic [2:0] DECODE  = 3'd3;
    localparam logic [2:0] EXEC    = 3'd4;
    localparam logic [2:0] MEM     = 3'd5;
    localparam logic [2:0] HALT    = 3'd6;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_JZ  = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] instr_count_q, instr_count_d;
    logic       timeout_err_q, timeout_err_d;
    logic [2:0] boundary;
    logic       acc_op;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_cnt_d    = wait_cnt_q;
        instr_count_d = instr_count_q;
        timeout_err_d = timeout_err_q;
        LoadPC        = 1'b0;
        IncPC         = 1'b0;
        LoadIR        = 1'b0;
        LoadAcc       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        addr_sel      = 1'b0;
        alu_op        = 2'b00;
        halted        = 1'b0;
        boundary      = run ? FETCH : IDLE;
        acc_op        = (op_q == OP_LDA) || (op_q == OP_ADD) || (op_q == OP_SUB);

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_d    = LOAD_IR;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = HALT;
                    timeout_err_d = 1'b1;
                    wait_cnt_d    = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            LOAD_IR: begin
                LoadIR        = 1'b1;
                IncPC         = 1'b1;
                instr_count_d = instr_count_q + 8'd1;
                state_d       = DECODE;
            end
            DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = MEM;
                    OP_JMP, OP_JZ:                  state_d = EXEC;
                    OP_HLT:                         state_d = HALT;
                    default:                        state_d = boundary;
                endcase
            end
            MEM: begin
                addr_sel = 1'b1;
                case (op_q)
                    OP_STA: MemWrite = 1'b1;
                    OP_LDA: MemRead  = 1'b1;
                    OP_ADD: begin
                        MemRead = 1'b1;
                        alu_op  = 2'b01;
                    end
                    OP_SUB: begin
                        MemRead = 1'b1;
                        alu_op  = 2'b10;
                    end
                    default: ;
                endcase
                // LoadAcc only on completion, so a timed-out access never writes ACC.
                if (mem_ready) begin
                    LoadAcc    = acc_op;
                    wait_cnt_d = '0;
                    state_d    = boundary;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = HALT;
                    timeout_err_d = 1'b1;
                    wait_cnt_d    = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            EXEC: begin
                LoadPC  = (op_q == OP_JMP) || ((op_q == OP_JZ) && zero_flag);
                state_d = boundary;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
    assign instr_count = instr_count_q;

endmodule
